// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches, decodes and steps each instruction
// through FETCH/DECODE/EXEC/MEM, driving an external register file and memory bus.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_btn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  reg_read_a,
  output logic [3:0]  reg_read_b,
  input  logic [15:0] reg_a_in,
  input  logic [15:0] reg_b_in,
  output logic [3:0]  reg_write,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        imm_sel,
  output logic [15:0] imm,
  output logic [7:0]  alu_op,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE,
    C_ITYPE,
    C_LOAD,
    C_STOR,
    C_JUMP,
    C_NOP,
    C_HALT
  } iclass_t;

  state_t  state, state_nx;
  iclass_t cls;
  logic [15:0] pc_nx;
  logic        ir_ld, pc_ld;
  logic [3:0]  op, rdest, ext, rsrc;

  assign op    = ir[15:12];
  assign rdest = ir[11:8];
  assign ext   = ir[7:4];
  assign rsrc  = ir[3:0];

  assign imm       = {{8{ir[7]}}, ir[7:0]};
  assign mem_wdata = reg_a_in;

  always_comb begin
    cls = C_ITYPE;
    if (op == 4'b0000) begin
      cls = C_RTYPE;
    end else if (op == 4'b1111) begin
      cls = C_HALT;
    end else if (op == 4'b0100) begin
      case (ext)
        4'b0000: cls = C_LOAD;
        4'b0100: cls = C_STOR;
        4'b1100: cls = C_JUMP;
        default: cls = C_NOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (ir_ld) ir <= mem_rdata;
      if (pc_ld) pc <= pc_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    ir_ld      = 1'b0;
    pc_ld      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    reg_read_a = '0;
    reg_read_b = '0;
    reg_write  = '0;
    reg_we     = 1'b0;
    wb_sel     = 1'b0;
    imm_sel    = 1'b0;
    alu_op     = '0;
    halted     = 1'b0;

    if (state != S_FETCH) begin
      reg_read_a = rdest;
      reg_read_b = rsrc;
    end

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_ld    = 1'b1;
          pc_ld    = 1'b1;
          pc_nx    = pc + 16'd1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          C_RTYPE, C_ITYPE: state_nx = S_EXEC;
          C_LOAD, C_STOR:   state_nx = S_MEM;
          C_JUMP: begin
            pc_ld    = 1'b1;
            pc_nx    = reg_b_in;
            state_nx = S_FETCH;
          end
          C_HALT:  state_nx = S_HALT;
          default: state_nx = S_FETCH;
        endcase
      end
      S_EXEC: begin
        reg_we    = 1'b1;
        reg_write = rdest;
        if (cls == C_RTYPE) begin
          alu_op = {op, ext};
        end else begin
          alu_op  = {op, 4'b0000};
          imm_sel = 1'b1;
        end
        state_nx = S_FETCH;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = reg_b_in;
        mem_we   = (cls == C_STOR);
        if (mem_ready) begin
          state_nx = S_FETCH;
          if (cls == C_LOAD) begin
            reg_we    = 1'b1;
            reg_write = rdest;
            wb_sel    = 1'b1;
          end
        end
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase

    // Strobes are gated by reset directly so an interrupted access (even a
    // STOR mid-wait) is dropped immediately, not at the next clock edge.
    if (!reset_btn) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      reg_we  = 1'b0;
      wb_sel  = 1'b0;
      imm_sel = 1'b0;
      alu_op  = '0;
      halted  = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a reference walk of the program fills the
// expected bus/write-back event queue; a monitor pops and compares each DUT event.
module tb_instr_sequencer;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk;
  logic        reset_btn;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [3:0]  reg_read_a, reg_read_b, reg_write;
  logic [15:0] reg_a_in, reg_b_in;
  logic        reg_we, wb_sel, imm_sel, halted;
  logic [15:0] imm, pc, ir;
  logic [7:0]  alu_op;

  logic [15:0] mem  [0:65535];
  logic [15:0] regs [0:15];

  assign reg_a_in = regs[reg_read_a];
  assign reg_b_in = regs[reg_read_b];

  instr_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_btn(reset_btn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .reg_read_a(reg_read_a), .reg_read_b(reg_read_b),
    .reg_a_in(reg_a_in), .reg_b_in(reg_b_in),
    .reg_write(reg_write), .reg_we(reg_we), .wb_sel(wb_sel),
    .imm_sel(imm_sel), .imm(imm), .alu_op(alu_op),
    .pc(pc), .ir(ir), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 = instruction fetch, 1 = data access, 2 = register write-back
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
    logic [3:0]  rd;
    logic        wb;
    logic [7:0]  alu;
    logic        isel;
    logic [15:0] imm;
    logic [15:0] pc;
    int          gap;
  } ev_t;

  ev_t sbq[$];

  // Peripheral space (bit 15) answers after 4 wait cycles, RAM with none.
  function automatic int wt(input logic [15:0] a);
    return a[15] ? 4 : 0;
  endfunction

  function automatic ev_t ev_new(input int kind);
    ev_t e;
    e.kind = kind; e.addr = '0; e.we = 1'b0; e.data = '0; e.rd = '0; e.wb = 1'b0;
    e.alu = '0; e.isel = 1'b0; e.imm = '0; e.pc = '0; e.gap = 0;
    return e;
  endfunction

  task automatic build(input logic [15:0] start, output logic [15:0] halt_pc);
    logic [15:0] p, w, a;
    logic [3:0]  o, rd, ex, rs;
    int          lat;
    bit          first;
    ev_t         e;
    p = start; lat = 0; first = 1'b1; halt_pc = '0;
    for (int n = 0; n < 64; n++) begin
      e = ev_new(0);
      e.addr = p;
      e.gap  = first ? 0 : lat + wt(p);
      first  = 1'b0;
      sbq.push_back(e);
      w = mem[p];
      p = p + 16'd1;
      o = w[15:12]; rd = w[11:8]; ex = w[7:4]; rs = w[3:0];
      if (o == 4'hF) begin
        halt_pc = p;
        break;
      end else if (o != 4'h4) begin
        e = ev_new(2);
        e.rd = rd; e.pc = p; e.imm = {{8{w[7]}}, w[7:0]};
        e.isel = (o != 4'h0);
        e.alu  = (o == 4'h0) ? {o, ex} : {o, 4'h0};
        sbq.push_back(e);
        lat = 3;
      end else if (ex == 4'h0 || ex == 4'h4) begin
        a = regs[rs];
        e = ev_new(1);
        e.addr = a; e.we = (ex == 4'h4); e.data = regs[rd];
        sbq.push_back(e);
        if (ex == 4'h0) begin
          e = ev_new(2);
          e.rd = rd; e.wb = 1'b1; e.pc = p;
          sbq.push_back(e);
        end
        lat = 3 + wt(a);
      end else if (ex == 4'hC) begin
        p = regs[rs];
        lat = 2;
      end else begin
        lat = 2;
      end
    end
  endtask

  int          cnt = 0, cyc = 0, req_len = 0, last_fetch = 0;
  logic [15:0] prev_addr = '0;
  ev_t         me;

  // Memory responder on the falling edge, monitor 1 time unit later.
  always begin
    @(negedge clk);
    mem_ready = 1'b0;
    if (reset_btn && mem_req) begin
      if (cnt >= wt(mem_addr)) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        cnt = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
      if (reset_btn) begin
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
      end
    end
    #1;
    cyc++;
    if (reset_btn) begin
      if (mem_req) begin
        req_len++;
        if (req_len > 1) check("addr_hold", mem_addr, prev_addr);
        prev_addr = mem_addr;
        check("alu_idle", {23'd0, imm_sel, alu_op}, 32'd0);
      end
      if (mem_req && mem_ready) begin
        if (sbq.size() == 0) begin
          check("sb_underflow_mem", 1, 0);
        end else begin
          me = sbq.pop_front();
          check("acc_kind", (me.kind != 2), 1);
          check("acc_addr", mem_addr, me.addr);
          check("acc_we", mem_we, me.we);
          if (me.we) check("acc_wdata", mem_wdata, me.data);
          if (me.kind == 0 && me.gap > 0) check("fetch_gap", cyc - last_fetch, me.gap);
          if (me.kind == 0) last_fetch = cyc;
          check("req_len", req_len, wt(mem_addr) + 1);
        end
        req_len = 0;
      end
      if (reg_we) begin
        if (sbq.size() == 0) begin
          check("sb_underflow_wr", 1, 0);
        end else begin
          me = sbq.pop_front();
          check("wr_kind", me.kind, 2);
          check("wr_reg", reg_write, me.rd);
          check("wr_wbsel", wb_sel, me.wb);
          check("wr_aluop", alu_op, me.alu);
          check("wr_immsel", imm_sel, me.isel);
          check("wr_pc", pc, me.pc);
          if (me.isel) check("wr_imm", imm, me.imm);
        end
      end
    end
  end

  task automatic wait_halt();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #3;
      if (halted) begin
        seen = 1'b1;
        break;
      end
    end
    check("halt_reached", seen, 1);
  endtask

  task automatic release_reset();
    @(negedge clk); #3;
    reset_btn = 1'b1;
    #1;
    check("rel_req", mem_req, 1);
    check("rel_addr", mem_addr, RST_PC);
  endtask

  logic [15:0] hpc;
  bit          found;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0100 + 16'(i);
    regs[1] = 16'hA5A5;
    regs[3] = 16'h8010;
    regs[4] = 16'h8200;
    regs[7] = 16'h0040;
    regs[8] = 16'hFFFF;
    mem[16'h0000] = 16'h0125;  // RTYPE r1, r5, ext 2
    mem[16'h0001] = 16'h53F0;  // ITYPE r3, imm F0
    mem[16'h0002] = 16'h4203;  // LOAD r2 <- [r3] (peripheral)
    mem[16'h0003] = 16'h4144;  // STOR r1 -> [r4] (peripheral)
    mem[16'h0004] = 16'h4135;  // NOP (unused ext)
    mem[16'h0005] = 16'h40C7;  // JUMP r7 = 0040
    mem[16'h0040] = 16'h40C8;  // JUMP r8 = FFFF
    mem[16'hFFFF] = 16'hF000;  // HALT, pc wraps to 0000
    mem[16'h8010] = 16'h1234;
    mem_ready = 1'b0;
    mem_rdata = '0;

    reset_btn = 1'b0;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_pc", pc, RST_PC);
    check("rst_ir", ir, 0);
    check("rst_halted", halted, 0);
    check("rst_ctl", {wb_sel, imm_sel, alu_op}, 0);

    build(RST_PC, hpc);
    release_reset();
    wait_halt();
    check("halt_pc", pc, hpc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      check("halt_hold_pc", pc, hpc);
      check("halt_hold_flag", halted, 1);
      check("halt_hold_strobes", {mem_req, mem_we, reg_we}, 0);
      check("halt_hold_ir", ir, 16'hF000);
    end
    check("sb_drained1", sbq.size(), 0);

    reset_btn = 1'b0;
    #1;
    check("halt_rst_pc", pc, RST_PC);
    check("halt_rst_flag", halted, 0);
    check("halt_rst_ir", ir, 0);
    sbq.delete();
    req_len = 0;
    build(RST_PC, hpc);
    release_reset();

    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (mem_req && mem_we && !mem_ready) begin
        found = 1'b1;
        break;
      end
    end
    check("stor_wait_seen", found, 1);
    reset_btn = 1'b0;
    #1;
    check("stor_rst_we", mem_we, 0);
    check("stor_rst_req", mem_req, 0);
    check("stor_rst_regwe", reg_we, 0);
    check("stor_rst_pc", pc, RST_PC);
    sbq.delete();
    req_len = 0;
    build(RST_PC, hpc);
    release_reset();
    wait_halt();
    check("halt_pc2", pc, hpc);
    check("sb_drained2", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'h0000, the PC value loaded at reset.
REQ-002 SHALL provide port clk  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port reset_btn  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide port mem_req  out  1  memory access request, held until mem_ready.
REQ-005 SHALL provide port mem_we  out  1  write strobe, valid only with mem_req.
REQ-006 SHALL provide port mem_addr  out  16  access address; bit 15 = 1 selects peripheral space.
REQ-007 SHALL provide port mem_wdata  out  16  store data (equals reg_a_in).
REQ-008 SHALL provide port mem_rdata  in  16  read data, valid in the cycle mem_ready = 1.
REQ-009 SHALL provide port mem_ready  in  1  access complete; any number of wait cycles allowed.
REQ-010 SHALL provide ports reg_read_a/reg_read_b  out  4 each  register file read selects.
REQ-011 SHALL provide ports reg_a_in/reg_b_in  in  16 each  register file read data (combinational).
REQ-012 SHALL provide ports reg_write  out  4 and reg_we  out  1  register file write select and enable.
REQ-013 SHALL provide port wb_sel  out  1  write-back source: 0 = ALU result, 1 = mem_rdata.
REQ-014 SHALL provide ports imm_sel  out  1 and imm  out  16  ALU B-operand select and sign-extended ir[7:0].
REQ-015 SHALL provide port alu_op  out  8  ALU operation code.
REQ-016 SHALL provide ports pc  out  16, ir  out  16, halted  out  1.

Function
REQ-017 SHALL decode fields op=ir[15:12], rdest=ir[11:8], ext=ir[7:4], rsrc=ir[3:0]; reg_read_a=rdest and reg_read_b=rsrc in every state except FETCH.
REQ-018 SHALL classify: op 0000 RTYPE; op 0100 ext 0000 LOAD, ext 0100 STOR, ext 1100 JUMP, other ext treated as NOP; op 1111 HALT; all other op ITYPE.
REQ-019 SHALL implement states FETCH, DECODE, EXEC, MEM, HALT; one-hot or binary encoding at implementer's choice.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=pc; remain while mem_ready=0; on mem_ready=1 latch ir<=mem_rdata, pc<=pc+1 (16-bit, FFFF wraps to 0000), go DECODE.
REQ-021 DECODE (1 cycle): RTYPE/ITYPE -> EXEC; LOAD/STOR -> MEM; JUMP -> pc<=reg_b_in, go FETCH; NOP -> FETCH; HALT -> HALT.
REQ-022 EXEC (1 cycle): reg_we=1, reg_write=rdest, wb_sel=0; alu_op={op,ext} for RTYPE with imm_sel=0, alu_op={op,4'b0000} for ITYPE with imm_sel=1; go FETCH.
REQ-023 MEM: mem_req=1, mem_addr=reg_b_in, mem_we=1 for STOR else 0; remain while mem_ready=0; on mem_ready=1 go FETCH, and for LOAD assert reg_we=1, reg_write=rdest, wb_sel=1 in that same cycle only.
REQ-024 reg_we SHALL never be asserted outside REQ-022/REQ-023; mem_req SHALL be 0 in DECODE, EXEC, HALT.
REQ-025 imm SHALL equal {{8{ir[7]}}, ir[7:0]} at all times; alu_op and imm_sel SHALL be 0 outside EXEC.
REQ-026 HALT: halted=1, all strobes 0, pc and ir frozen; exit only via reset.
REQ-027 Zero-wait latency SHALL be: RTYPE/ITYPE 3 cycles, LOAD/STOR 3 cycles, JUMP/NOP 2 cycles, fetch-to-fetch.
REQ-028 mem_ready asserted while mem_req=0 SHALL be ignored.

Reset
REQ-029 While reset_btn=0 SHALL force, asynchronously: state=FETCH, pc=RESET_PC, ir=0, halted=0, and mem_req, mem_we, reg_we, wb_sel, imm_sel, alu_op to 0.
REQ-030 Reset asserted mid-access (including a STOR with mem_we=1) SHALL drop mem_we and reg_we in the same cycle, with no write-back of the interrupted instruction.
REQ-031 After reset_btn rises, the first rising edge SHALL begin FETCH at RESET_PC.

Verification
REQ-032 Zero-wait memory, mem[0]=16'h0125 (RTYPE r1,r5, ext 2) -> DECODE next cycle, EXEC with alu_op=8'h02, reg_write=1, reg_we=1; pc=1 at EXEC.
REQ-033 ITYPE 16'h53F0 -> imm=16'hFFF0, imm_sel=1, alu_op=8'h50, reg_write=3.
REQ-034 LOAD 16'h4203 with reg_b_in=16'h8010 and mem_ready delayed 4 cycles -> mem_addr=16'h8010 held 5 cycles; reg_we pulses once with wb_sel=1, reg_write=2.
REQ-035 JUMP 16'h40C7 with reg_b_in=16'h0040 -> next FETCH mem_addr=16'h0040; pc=FFFF fetch -> pc wraps to 0000.
REQ-036 HALT 16'hF000 -> halted=1, pc frozen for 20 cycles, mem_req=0; reset_btn pulse low -> pc=RESET_PC, halted=0.
REQ-037 Reset asserted during STOR MEM wait -> mem_we=0 before next edge, state FETCH, pc=RESET_PC.
